trie_lookup_arbiter: RTL

- Shares one pipelined 4-bit-stride trie lookup pipeline among NUM_REQ lookup requesters.
- Arbitrates round-robin and issues at most one IP per cycle into the pipeline.
- Tracks each in-flight lookup's owner through a fixed-latency tag shift register.
- Steers each returned nexthop into a per-requester response FIFO. Credit-based issue guarantees that no result is ever dropped.

---
 rtl/trie_lookup_arbiter.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/trie_lookup_arbiter.sv
// Round-robin front end for a shared fixed-latency trie lookup pipeline.
// Tags track each lookup's owner; credits guarantee every result has a FIFO slot.
module trie_lookup_arbiter #(
   parameter int NUM_REQ      = 4,
   parameter int PIPE_LATENCY = 9,
   parameter int FIFO_DEPTH   = 4,
   parameter int IP_W         = 32,
   parameter int NH_W         = 8
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*IP_W-1:0]   req_ip,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [IP_W-1:0]           trie_ip,
   input  logic [NH_W-1:0]           trie_nexthop,
   output logic [NUM_REQ-1:0]        rsp_valid,
   output logic [NUM_REQ*NH_W-1:0]   rsp_nexthop,
   input  logic [NUM_REQ-1:0]        rsp_ready,
   output logic                      busy
);

   localparam int IDX_W = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   // One extra stage so the last tag lines up with the result in the cycle it is valid.
   localparam int TAGS  = PIPE_LATENCY + 1;

   logic [CNT_W-1:0] creditQ [NUM_REQ];
   logic [CNT_W-1:0] countQ  [NUM_REQ];
   logic [PTR_W-1:0] wrPtrQ  [NUM_REQ];
   logic [PTR_W-1:0] rdPtrQ  [NUM_REQ];
   logic [NH_W-1:0]  memQ    [NUM_REQ][FIFO_DEPTH];
   logic [IDX_W-1:0] tagIdQ  [TAGS];
   logic [TAGS-1:0]  tagValidQ;
   logic [IDX_W-1:0] rrPtrQ;
   logic [IP_W-1:0]  trieIpQ;

   logic [NUM_REQ-1:0]   eligible;
   logic [2*NUM_REQ-1:0] eligRot;
   logic [NUM_REQ-1:0]   grantD;
   logic [IDX_W-1:0]     grantIdx;
   logic                 grantValid;
   logic [IDX_W:0]       candidate;
   logic [NUM_REQ-1:0]   pushVec;
   logic [NUM_REQ-1:0]   popVec;

   always_comb begin
      eligible = '0;
      pushVec  = '0;
      popVec   = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         eligible[i]  = req_valid[i] && (creditQ[i] != '0);
         rsp_valid[i] = (countQ[i] != '0);
         popVec[i]    = rsp_valid[i] && rsp_ready[i];
         pushVec[i]   = tagValidQ[TAGS-1] && (tagIdQ[TAGS-1] == IDX_W'(i));
      end
   end

   // Rotate eligibility so bit 0 is rr_ptr, then take the first set bit.
   always_comb begin
      eligRot    = {eligible, eligible} >> rrPtrQ;
      grantValid = 1'b0;
      grantIdx   = '0;
      candidate  = '0;
      grantD     = '0;
      for (int off = 0; off < NUM_REQ; off++) begin
         if (!grantValid && eligRot[off]) begin
            grantValid = 1'b1;
            candidate  = {1'b0, rrPtrQ} + (IDX_W+1)'(off);
            if (candidate >= (IDX_W+1)'(NUM_REQ)) begin
               candidate = candidate - (IDX_W+1)'(NUM_REQ);
            end
            grantIdx = candidate[IDX_W-1:0];
         end
      end
      if (!rst) begin
         grantValid = 1'b0;
      end
      if (grantValid) begin
         grantD[grantIdx] = 1'b1;
      end
   end

   assign req_ready = grantD;
   assign trie_ip   = trieIpQ;
   assign busy      = (|tagValidQ) || (|rsp_valid);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tagValidQ <= '0;
         rrPtrQ    <= '0;
         trieIpQ   <= '0;
         for (int k = 0; k < TAGS; k++) begin
            tagIdQ[k] <= '0;
         end
      end else begin
         tagValidQ <= {tagValidQ[TAGS-2:0], grantValid};
         tagIdQ[0] <= grantIdx;
         for (int k = 1; k < TAGS; k++) begin
            tagIdQ[k] <= tagIdQ[k-1];
         end
         if (grantValid) begin
            trieIpQ <= req_ip[int'(grantIdx)*IP_W +: IP_W];
            rrPtrQ  <= (int'(grantIdx) == NUM_REQ-1) ? '0 : grantIdx + 1'b1;
         end
      end
   end

   // Credits and response FIFOs; a same-cycle grant and pop leave the credit alone.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REQ; i++) begin
            creditQ[i] <= CNT_W'(FIFO_DEPTH);
            countQ[i]  <= '0;
            wrPtrQ[i]  <= '0;
            rdPtrQ[i]  <= '0;
            for (int e = 0; e < FIFO_DEPTH; e++) begin
               memQ[i][e] <= '0;
            end
         end
      end else begin
         for (int i = 0; i < NUM_REQ; i++) begin
            case ({grantD[i], popVec[i]})
               2'b10:   creditQ[i] <= creditQ[i] - 1'b1;
               2'b01:   creditQ[i] <= creditQ[i] + 1'b1;
               default: creditQ[i] <= creditQ[i];
            endcase
            case ({pushVec[i], popVec[i]})
               2'b10:   countQ[i] <= countQ[i] + 1'b1;
               2'b01:   countQ[i] <= countQ[i] - 1'b1;
               default: countQ[i] <= countQ[i];
            endcase
            if (pushVec[i]) begin
               memQ[i][wrPtrQ[i]] <= trie_nexthop;
               wrPtrQ[i]          <= wrPtrQ[i] + 1'b1;
            end
            if (popVec[i]) begin
               rdPtrQ[i] <= rdPtrQ[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      rsp_nexthop = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         rsp_nexthop[i*NH_W +: NH_W] = memQ[i][rdPtrQ[i]];
      end
   end

   for (genvar g = 0; g < NUM_REQ; g++) begin : gPushCheck
      assert property (@(posedge clk) disable iff (!rst)
         !(pushVec[g] && (countQ[g] == CNT_W'(FIFO_DEPTH)) && !popVec[g]));
   end

endmodule
